// File: rtl/pcm_rom_fetch.sv
// pcm_rom_fetch: byte-read front end for the PCM sample ROM held in DDRAM ch1.
// A direct-mapped cache of 64-bit words answers hits one cycle after rd_req.
// A miss fetches the whole word. PCM playback is linear, so after each demand
// fill the following word is optionally prefetched.

module pcm_rom_fetch #(
  parameter int ADDR_W   = 18,
  parameter int IDX_W    = 2,
  parameter bit PREFETCH = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_rdy,
  output logic              rd_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [63:0]       mem_dout,
  input  logic              mem_ready
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PREF
  } state_t;

  state_t            state;

  // Cache storage: one 64-bit word per line.
  logic [63:0]       line_data [LINES];
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [LINES-1:0]  line_valid;

  // Byte offset of the outstanding demand read.
  logic [2:0]        byte_off;

  // A read that arrived during a prefetch. It waits here until the prefetch lands.
  logic              pend_v;
  logic [ADDR_W-1:0] pend_addr;

  // Set while a DDRAM answer to a request abandoned by reset is still owed.
  logic              drop;

  // Fill port. The line being written is the word currently on mem_addr.
  logic              fill_en;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic [7:0]        fill_byte;

  assign fill_en   = (state != IDLE) && mem_req && mem_ready;
  assign fill_idx  = mem_addr[IDX_W+2:3];
  assign fill_tag  = mem_addr[ADDR_W-1:IDX_W+3];
  assign fill_byte = mem_dout[{byte_off, 3'b000} +: 8];

  // Lookup port for reads: the live rd_req, or during a prefetch the newest read.
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              req_hit;
  logic [63:0]       req_word;
  logic [7:0]        req_byte;
  logic              serve_now;

  // Choose which address is presented to the lookup.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first. Without one, a path that skips the assignment infers a latch.
    req_valid = rd_req;
    req_addr  = rd_addr;
    if (state == PREF && !rd_req) begin
      req_valid = pend_v;
      req_addr  = pend_addr;
    end
  end

  assign req_idx = req_addr[IDX_W+2:3];
  assign req_tag = req_addr[ADDR_W-1:IDX_W+3];

  // Tag compare for reads. A fill landing on the same line this cycle takes
  // precedence, so the lookup sees the new word.
  always_comb begin
    req_hit  = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    req_word = line_data[req_idx];
    if (fill_en && (fill_idx == req_idx)) begin
      req_hit  = (fill_tag == req_tag);
      req_word = mem_dout;
    end
  end

  assign req_byte = req_word[{req_addr[2:0], 3'b000} +: 8];

  // A read is looked up when it arrives in IDLE. A read parked during a
  // prefetch is looked up on the cycle the prefetched word arrives.
  assign serve_now = ((state == IDLE) && rd_req) ||
                     ((state == PREF) && fill_en && req_valid);

  // Prefetch candidate. The word address wraps at the top of the ROM.
  logic [ADDR_W-1:0] next_addr;
  logic [IDX_W-1:0]  next_idx;
  logic [TAG_W-1:0]  next_tag;
  logic              next_hit;

  assign next_addr = {mem_addr[ADDR_W-1:3] + {{(ADDR_W-4){1'b0}}, 1'b1}, 3'b000};
  assign next_idx  = next_addr[IDX_W+2:3];
  assign next_tag  = next_addr[ADDR_W-1:IDX_W+3];

  // Decide whether the word after the demand fill is already cached. This
  // accounts for the line being written this cycle.
  always_comb begin
    next_hit = line_valid[next_idx] && (line_tag[next_idx] == next_tag);
    if (fill_en && (fill_idx == next_idx)) begin
      next_hit = (fill_tag == next_tag);
    end
  end

  // Line storage: write the returned word and its tag on every accepted fill.
  always_ff @(posedge clk_sys) begin
    // NOTE: the data and tag arrays have no reset. The valid bits alone decide
    // whether a line can hit, so leftover contents after reset are harmless.
    if (!reset && fill_en) begin
      line_data[fill_idx] <= mem_dout;
      line_tag[fill_idx]  <= fill_tag;
    end
  end

  // Control FSM, registered outputs, valid bits, pending slot and drain flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      rd_data    <= '0;
      rd_rdy     <= 1'b0;
      rd_busy    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      byte_off   <= '0;
      pend_v     <= 1'b0;
      pend_addr  <= '0;
      line_valid <= '0;
      // DDRAM still answers a request that reset abandons, so remember to
      // swallow that answer. An answer already owed stays owed.
      drop       <= drop | mem_req;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // right-hand side sees start-of-cycle values, and a later assignment in
      // this block overrides an earlier one.
      rd_rdy <= 1'b0;

      if (fill_en) begin
        line_valid[fill_idx] <= 1'b1;
      end

      if (drop && mem_ready) begin
        drop <= 1'b0;
      end

      case (state)
        IDLE: ;

        FILL: begin
          if (!mem_req) begin
            // Hold off until the stale answer has drained (or drains now).
            if (!drop || mem_ready) begin
              mem_req <= 1'b1;
            end
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            rd_busy <= 1'b0;
            rd_rdy  <= 1'b1;
            rd_data <= fill_byte;
            if (PREFETCH && !next_hit) begin
              state    <= PREF;
              mem_addr <= next_addr;
            end else begin
              state <= IDLE;
            end
          end
        end

        PREF: begin
          if (rd_req) begin
            pend_v    <= 1'b1;
            pend_addr <= rd_addr;
            rd_busy   <= 1'b1;
          end
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            pend_v  <= 1'b0;
            rd_busy <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Lookup outcome. It comes after the case so it overrides the defaults
      // set there when a parked read is serviced as the prefetch lands.
      if (serve_now) begin
        if (req_hit) begin
          rd_rdy  <= 1'b1;
          rd_data <= req_byte;
        end else begin
          state    <= FILL;
          rd_busy  <= 1'b1;
          mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
          byte_off <= req_addr[2:0];
          mem_req  <= !drop || mem_ready;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_rom_fetch.sv
// tb_pcm_rom_fetch: randomized self-checking bench for pcm_rom_fetch.
// A DDRAM responder returns words of a synthetic ROM. A word-granular cache
// model predicts hits, misses, prefetches and returned bytes.

module tb_pcm_rom_fetch;

  localparam int ADDR_W = 18;
  localparam int IDX_W  = 2;
  localparam int WW     = ADDR_W - 3;
  localparam int LINES  = 1 << IDX_W;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              rd_rdy;
  logic              rd_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic [63:0]       mem_dout;
  logic              mem_ready;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  bit                resp_en = 1'b0;
  int                resp_lat_max = 4;
  logic [ADDR_W-1:0] served_q[$];
  int                last_ready_cycle = -10;

  // Cache model: which word address each line holds.
  logic [WW-1:0] m_word  [LINES];
  bit            m_valid [LINES];

  pcm_rom_fetch #(
    .ADDR_W  (ADDR_W),
    .IDX_W   (IDX_W),
    .PREFETCH(1'b1)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_rdy   (rd_rdy),
    .rd_busy  (rd_busy),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_dout (mem_dout),
    .mem_ready(mem_ready)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cycle <= cycle + 1;

  function automatic logic [63:0] rom_word(input logic [WW-1:0] w);
    logic [31:0] x;
    if (w == '0) return 64'h8877665544332211;
    x = 32'(w);
    return {x * 32'h9E3779B1, ~(x * 32'h85EBCA77)};
  endfunction

  function automatic logic [7:0] rom_byte(input logic [ADDR_W-1:0] a);
    logic [63:0] d;
    d = rom_word(a[ADDR_W-1:3]);
    return d[8*a[2:0] +: 8];
  endfunction

  function automatic bit m_hit(input logic [WW-1:0] w);
    int i = int'(w) % LINES;
    return m_valid[i] && (m_word[i] == w);
  endfunction

  function automatic void m_fill(input logic [WW-1:0] w);
    int i = int'(w) % LINES;
    m_valid[i] = 1'b1;
    m_word[i]  = w;
  endfunction

  // DDRAM ch1 model: answers each request after 1..resp_lat_max cycles.
  always begin : ddram
    logic [ADDR_W-1:0] a;
    int                lat;
    @(negedge clk_sys);
    if (resp_en && mem_req === 1'b1) begin
      a   = mem_addr;
      lat = $urandom_range(1, resp_lat_max);
      repeat (lat) begin
        @(negedge clk_sys);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== a) begin
          fails++;
          $display("FAIL ddram_hold: mem_req=%b mem_addr=%h, required 1 / %h", mem_req, mem_addr, a);
        end
      end
      mem_dout  = rom_word(a[ADDR_W-1:3]);
      mem_ready = 1'b1;
      served_q.push_back(a);
      last_ready_cycle = cycle;
      @(negedge clk_sys);
      mem_ready = 1'b0;
      mem_dout  = {$urandom, $urandom};
    end
  end

  task automatic do_reset();
    reset  = 1'b1;
    rd_req = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    served_q.delete();
  endtask

  task automatic idle_wait(input string name);
    int quiet = 0;
    for (int i = 0; i < 80 && quiet < 4; i++) begin
      @(negedge clk_sys);
      if (mem_req === 1'b0 && rd_busy === 1'b0 && mem_ready === 1'b0) quiet++;
      else quiet = 0;
    end
    tests++;
    if (quiet < 4) begin
      fails++;
      $display("FAIL %s idle_timeout: mem_req=%b rd_busy=%b, required 0 / 0", name, mem_req, rd_busy);
    end
  endtask

  // One read issued from idle, checked against the model, then left idle again.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input string name);
    logic [WW-1:0]     w;
    logic [WW-1:0]     nw;
    logic [7:0]        exp;
    logic [ADDR_W-1:0] exp_fetch[$];
    bit                hit;
    bit                got;
    int                base;
    w    = addr[ADDR_W-1:3];
    nw   = WW'(int'(w) + 1);
    exp  = rom_byte(addr);
    hit  = m_hit(w);
    base = served_q.size();
    if (!hit) begin
      exp_fetch.push_back({w, 3'b000});
      m_fill(w);
      if (!m_hit(nw)) begin
        exp_fetch.push_back({nw, 3'b000});
        m_fill(nw);
      end
    end
    rd_req  = 1'b1;
    rd_addr = addr;
    @(negedge clk_sys);
    rd_req = 1'b0;
    if (hit) begin
      tests++;
      if (rd_rdy !== 1'b1 || rd_data !== exp) begin
        fails++;
        $display("FAIL %s hit_data: rd_rdy=%b rd_data=%h, required 1 / %h", name, rd_rdy, rd_data, exp);
      end
      tests++;
      if (mem_req !== 1'b0 || rd_busy !== 1'b0) begin
        fails++;
        $display("FAIL %s hit_quiet: mem_req=%b rd_busy=%b, required 0 / 0", name, mem_req, rd_busy);
      end
    end else begin
      tests++;
      if (rd_rdy !== 1'b0 || rd_busy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== {w, 3'b000}) begin
        fails++;
        $display("FAIL %s miss_start: rdy=%b busy=%b req=%b addr=%h, required 0/1/1/%h",
                 name, rd_rdy, rd_busy, mem_req, mem_addr, {w, 3'b000});
      end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk_sys);
        if (rd_rdy === 1'b1) got = 1'b1;
      end
      tests++;
      if (!got || rd_data !== exp || rd_busy !== 1'b0) begin
        fails++;
        $display("FAIL %s miss_data: seen=%b rd_data=%h rd_busy=%b, required 1 / %h / 0",
                 name, got, rd_data, rd_busy, exp);
      end
    end
    idle_wait(name);
    tests++;
    if (served_q.size() != base + exp_fetch.size()) begin
      fails++;
      $display("FAIL %s fetch_count: got %0d fetches, required %0d", name, served_q.size() - base, exp_fetch.size());
    end else begin
      foreach (exp_fetch[i]) begin
        tests++;
        if (served_q[base+i] !== exp_fetch[i]) begin
          fails++;
          $display("FAIL %s fetch_addr[%0d]: got %h, required %h", name, i, served_q[base+i], exp_fetch[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (rd_data !== 8'h00 || rd_rdy !== 1'b0 || rd_busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== '0) begin
      fails++;
      $display("FAIL reset_values: data=%h rdy=%b busy=%b req=%b addr=%h, required 00/0/0/0/0",
               rd_data, rd_rdy, rd_busy, mem_req, mem_addr);
    end
  endtask

  task automatic test_miss_prefetch();
    do_read(18'h00005, "t1_miss");
    tests++;
    if (rd_data !== 8'h66) begin
      fails++;
      $display("FAIL t1_byte: rd_data=%h, required 66", rd_data);
    end
  endtask

  task automatic test_hit();
    do_read(18'h00003, "t2_hit");
  endtask

  task automatic test_pending_during_pref();
    bit got;
    do_reset();
    rd_req  = 1'b1;
    rd_addr = 18'h00005;
    @(negedge clk_sys);
    rd_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_sys);
      if (rd_rdy === 1'b1) got = 1'b1;
    end
    tests++;
    if (!got || rd_data !== 8'h66) begin
      fails++;
      $display("FAIL t3_demand: seen=%b rd_data=%h, required 1 / 66", got, rd_data);
    end
    rd_req  = 1'b1;
    rd_addr = 18'h0000A;
    @(negedge clk_sys);
    rd_req = 1'b0;
    tests++;
    if (rd_busy !== 1'b1 || rd_rdy !== 1'b0) begin
      fails++;
      $display("FAIL t3_pending_busy: rd_busy=%b rd_rdy=%b, required 1 / 0", rd_busy, rd_rdy);
    end
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk_sys);
      if (rd_rdy === 1'b1) begin
        got = 1'b1;
        tests++;
        if (cycle != last_ready_cycle + 1 || rd_data !== rom_byte(18'h0000A) || rd_busy !== 1'b0) begin
          fails++;
          $display("FAIL t3_pending_rdy: lag=%0d rd_data=%h rd_busy=%b, required 1 / %h / 0",
                   cycle - last_ready_cycle, rd_data, rd_busy, rom_byte(18'h0000A));
        end
      end else if (rd_busy !== 1'b1) begin
        tests++;
        fails++;
        $display("FAIL t3_busy_hold: rd_busy=%b, required 1", rd_busy);
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL t3_pending_timeout: rd_rdy never seen, required 1");
    end
    idle_wait("t3");
    tests++;
    if (served_q.size() != 2 || served_q[0] !== 18'h00000 || served_q[1] !== 18'h00008) begin
      fails++;
      $display("FAIL t3_fetches: got %0d fetches, required 2 (00000, 00008)", served_q.size());
    end
    m_fill(WW'(0));
    m_fill(WW'(1));
  endtask

  task automatic test_wrap();
    do_reset();
    do_read(18'h3FFFF, "t4_wrap");
  endtask

  task automatic test_conflict();
    do_reset();
    do_read(18'h00000, "t5_fill0");
    do_read(18'h00020, "t5_conflict");
    do_read(18'h00000, "t5_refetch");
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    do_reset();
    do_read(18'h00000, "b2b_fill");
    for (int k = 0; k < 16; k++) begin
      a       = ADDR_W'($urandom_range(0, 15));
      rd_req  = 1'b1;
      rd_addr = a;
      @(negedge clk_sys);
      tests++;
      if (rd_rdy !== 1'b1 || rd_data !== rom_byte(a) || mem_req !== 1'b0) begin
        fails++;
        $display("FAIL b2b[%0d]: rdy=%b data=%h req=%b, required 1 / %h / 0", k, rd_rdy, rd_data, mem_req, rom_byte(a));
      end
    end
    rd_req = 1'b0;
    idle_wait("b2b");
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    do_reset();
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 3) == 0) a = ADDR_W'($urandom);
      else a = ADDR_W'($urandom_range(0, 8'h7F));
      do_read(a, $sformatf("rnd%0d", k));
    end
  endtask

  task automatic test_reset_mid_fill();
    bit got;
    do_reset();
    resp_en = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 18'h00010;
    @(negedge clk_sys);
    rd_req = 1'b0;
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL t6_first_req: mem_req=%b, required 1", mem_req);
    end
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    tests++;
    if (mem_req !== 1'b0 || rd_busy !== 1'b0 || rd_rdy !== 1'b0 || rd_data !== 8'h00) begin
      fails++;
      $display("FAIL t6_after_reset: req=%b busy=%b rdy=%b data=%h, required 0/0/0/00",
               mem_req, rd_busy, rd_rdy, rd_data);
    end
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 18'h00018;
    @(negedge clk_sys);
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (mem_req !== 1'b0 || rd_busy !== 1'b1) begin
        fails++;
        $display("FAIL t6_drain_wait[%0d]: mem_req=%b rd_busy=%b, required 0 / 1", i, mem_req, rd_busy);
      end
      if (i < 3) @(negedge clk_sys);
    end
    mem_dout  = ~rom_word(WW'(2));
    mem_ready = 1'b1;
    @(negedge clk_sys);
    mem_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tests++;
      if (rd_rdy !== 1'b0) begin
        fails++;
        $display("FAIL t6_stale_dropped: rd_rdy=%b, required 0", rd_rdy);
      end
      if (mem_req === 1'b1) got = 1'b1;
      else @(negedge clk_sys);
    end
    tests++;
    if (!got || mem_addr !== 18'h00018) begin
      fails++;
      $display("FAIL t6_rerequest: mem_req=%b mem_addr=%h, required 1 / 00018", mem_req, mem_addr);
    end
    mem_dout  = rom_word(WW'(3));
    mem_ready = 1'b1;
    @(negedge clk_sys);
    mem_ready = 1'b0;
    tests++;
    if (rd_rdy !== 1'b1 || rd_data !== rom_byte(18'h00018)) begin
      fails++;
      $display("FAIL t6_fill_data: rd_rdy=%b rd_data=%h, required 1 / %h", rd_rdy, rd_data, rom_byte(18'h00018));
    end
    resp_en = 1'b1;
    idle_wait("t6");
    tests++;
    if (served_q.size() != 1 || served_q[0] !== 18'h00020) begin
      fails++;
      $display("FAIL t6_prefetch: got %0d fetches, required 1 (00020)", served_q.size());
    end
    m_fill(WW'(3));
    m_fill(WW'(4));
    do_read(18'h00021, "t6_prefetched_hit");
  endtask

  initial begin
    reset     = 1'b1;
    rd_req    = 1'b0;
    rd_addr   = '0;
    mem_dout  = '0;
    mem_ready = 1'b0;
    @(negedge clk_sys);
    test_reset();
    resp_en = 1'b1;
    test_miss_prefetch();
    test_hit();
    test_pending_during_pref();
    test_wrap();
    test_conflict();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
